// File: rtl/gl_video_pkg.sv
// Shared video-pipeline types and helpers for the gl4 stages.
package gl_video_pkg;

    localparam int GL_D_WIDTH = 8;

    typedef struct packed {
        logic                  tuser;
        logic                  tlast;
        logic [GL_D_WIDTH-1:0] data;
    } beat_t;

    // Width of a counter that spans 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gl4_reframe_if.sv
// Valid/ready video stream with AXI-style tlast/tuser sidebands.
interface gl4_reframe_if #(parameter int D_WIDTH = 8);
    logic [D_WIDTH-1:0] data;
    logic               valid;
    logic               tlast;
    logic               tuser;
    logic               ready;

    modport master (output data, valid, tlast, tuser, input ready);
    modport slave  (input data, valid, tlast, tuser, output ready);
endinterface

// File: rtl/gl4_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is presented directly from storage.
module gl4_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             full, empty, push, pop;

    // Extra pointer MSB separates the full and empty cases when the indices match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = wr_valid && !full;
    assign pop   = !empty && rd_ready;

    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign level    = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is reset so the idle head reads as zero rather than unknown.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_comb begin
            mem_d[gi] = mem_q[gi];
            if (push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
                mem_d[gi] = wr_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end
endmodule

// File: rtl/gl4_reframe.sv
// Re-frames the decimated stream: regenerates tlast from a column count, realigns on tuser.
module gl4_reframe
    import gl_video_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int OUT_W   = 960,
    parameter int OUT_H   = 540,
    parameter int DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    gl4_reframe_if.slave           up,
    gl4_reframe_if.master          down,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err_sof_early,
    output logic                   err_sof_missing
);
    localparam int CW = cnt_w(OUT_W);
    localparam int RW = cnt_w(OUT_H);
    localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(OUT_H - 1);

    typedef struct packed {
        logic               tuser;
        logic               tlast;
        logic [D_WIDTH-1:0] data;
    } frame_beat_t;

    logic [CW-1:0] col_q, col_d, ec;
    logic [RW-1:0] row_q, row_d, er;
    logic          seen_sof_q, seen_sof_d;
    logic          early_q, early_d;
    logic          missing_q, missing_d;
    logic          up_ready_w, push, at_origin;
    frame_beat_t   wr_beat, rd_beat;

    assign push      = up.valid && up_ready_w;
    assign at_origin = (col_q == '0) && (row_q == '0);

    always_comb begin
        ec         = up.tuser ? '0 : col_q;
        er         = up.tuser ? '0 : row_q;
        col_d      = col_q;
        row_d      = row_q;
        seen_sof_d = seen_sof_q;
        early_d    = early_q;
        missing_d  = missing_q;

        wr_beat.tuser = up.tuser;
        wr_beat.tlast = (ec == LAST_COL);
        wr_beat.data  = up.data;

        if (push) begin
            if (ec == LAST_COL) begin
                col_d = '0;
                row_d = (er == LAST_ROW) ? '0 : er + RW'(1);
            end else begin
                col_d = ec + CW'(1);
                row_d = er;
            end
            // Missing-SOF is only meaningful once the stream has shown a frame start.
            if (up.tuser) begin
                seen_sof_d = 1'b1;
                if (!at_origin) early_d = 1'b1;
            end else if (at_origin && seen_sof_q) begin
                missing_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            seen_sof_q <= 1'b0;
            early_q    <= 1'b0;
            missing_q  <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            seen_sof_q <= seen_sof_d;
            early_q    <= early_d;
            missing_q  <= missing_d;
        end
    end

    gl4_fifo #(
        .WIDTH ($bits(frame_beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_beat),
        .wr_valid (up.valid),
        .wr_ready (up_ready_w),
        .rd_data  (rd_beat),
        .rd_valid (down.valid),
        .rd_ready (down.ready),
        .level    (level)
    );

    assign up.ready        = up_ready_w;
    assign down.data       = rd_beat.data;
    assign down.tlast      = rd_beat.tlast;
    assign down.tuser      = rd_beat.tuser;
    assign err_sof_early   = early_q;
    assign err_sof_missing = missing_q;
endmodule

// File: tb/tb_gl4_reframe.sv
// Randomised bench for gl4_reframe with a frame-position reference model and scoreboard.
module tb_gl4_reframe;
    localparam int DW  = 8;
    localparam int OW  = 4;
    localparam int OH  = 2;
    localparam int DEP = 4;
    localparam int LW  = $clog2(DEP) + 1;

    typedef struct packed {
        logic          tuser;
        logic          tlast;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [LW-1:0] level;
    logic err_early, err_missing;

    always #5 clk = ~clk;

    gl4_reframe_if #(.D_WIDTH(DW)) up_if ();
    gl4_reframe_if #(.D_WIDTH(DW)) down_if ();

    gl4_reframe #(.D_WIDTH(DW), .OUT_W(OW), .OUT_H(OH), .DEPTH(DEP)) dut (
        .clk             (clk),
        .rst             (rst),
        .up              (up_if),
        .down            (down_if),
        .level           (level),
        .err_sof_early   (err_early),
        .err_sof_missing (err_missing)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   m_pos = 0;
    bit   m_seen = 0, m_early = 0, m_missing = 0;
    bit   stall_prev = 0;
    exp_t held;

    // Reference model: a linear position within the frame, reset to 0 by tuser.
    function automatic void model_push(input bit tu, input logic [DW-1:0] d);
        exp_t e;
        if (tu && m_pos != 0) m_early = 1;
        if (!tu && m_pos == 0 && m_seen) m_missing = 1;
        if (tu) begin
            m_seen = 1;
            m_pos  = 0;
        end
        e.tuser = tu;
        e.tlast = ((m_pos % OW) == OW - 1);
        e.data  = d;
        exp_q.push_back(e);
        m_pos = (m_pos + 1) % (OW * OH);
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        m_pos = 0; m_seen = 0; m_early = 0; m_missing = 0;
    endfunction

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t act, e;
        act = {down_if.tuser, down_if.tlast, down_if.data};
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!down_if.valid || act !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b beat=%0h, required valid=1 beat=%0h", down_if.valid, act, held);
                end
            end
            if (down_if.valid && down_if.ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got beat=%0h, required no beat", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL pop_beat: got %0h, required %0h", act, e);
                    end
                end
            end
            stall_prev = down_if.valid && !down_if.ready;
            held = act;
            if (up_if.valid && up_if.ready) model_push(up_if.tuser, up_if.data);
        end
    end

    task automatic send(input bit tu, input logic [DW-1:0] d);
        int n = 0;
        bit acc = 0;
        up_if.valid = 1; up_if.tuser = tu; up_if.data = d; up_if.tlast = 1'($urandom_range(0, 1));
        while (!acc) begin
            @(negedge clk);
            acc = up_if.ready;
            @(posedge clk); #1;
            if (!acc) begin
                n++;
                if (n > 200) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: got no accept in 200 cycles, required accept");
                    acc = 1;
                end
            end
        end
        up_if.valid = 0; up_if.tuser = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1; up_if.valid = 0; up_if.tuser = 0;
        model_clear();
        idle(2);
        rst = 0;
        idle(1);
    endtask

    task automatic test_reset();
        up_if.valid = 0; up_if.tuser = 0; up_if.data = '0; up_if.tlast = 0; down_if.ready = 0;
        #1;
        checks++;
        if (down_if.valid !== 0 || up_if.ready !== 1 || level !== 0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%0b ready=%0b level=%0d, required 0 1 0", down_if.valid, up_if.ready, level);
        end
        checks++;
        if (down_if.tlast !== 0 || down_if.tuser !== 0 || down_if.data !== 0 || err_early !== 0 || err_missing !== 0) begin
            errors++;
            $display("FAIL reset_data: got tlast=%0b tuser=%0b data=%0h early=%0b missing=%0b, required all 0",
                     down_if.tlast, down_if.tuser, down_if.data, err_early, err_missing);
        end
        idle(2);
        rst = 0;
        idle(1);
    endtask

    task automatic test_frame();
        down_if.ready = 1;
        for (int i = 0; i < OW * OH; i++) begin
            send(i == 0, 8'(i));
            checks++;
            if (down_if.valid !== 1 || down_if.data !== 8'(i) || down_if.tlast !== (i % OW == OW - 1) || down_if.tuser !== (i == 0)) begin
                errors++;
                $display("FAIL frame_beat%0d: got v=%0b d=%0h last=%0b user=%0b, required v=1 d=%0h last=%0b user=%0b", i,
                         down_if.valid, down_if.data, down_if.tlast, down_if.tuser, 8'(i), (i % OW == OW - 1), (i == 0));
            end
        end
        idle(2);
        checks++;
        if (err_early !== 0 || err_missing !== 0 || level !== 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_end: got early=%0b missing=%0b level=%0d pending=%0d, required 0 0 0 0", err_early, err_missing, level, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        down_if.ready = 0;
        for (int i = 0; i < DEP; i++) send(i == 0, 8'(i));
        checks++;
        if (up_if.ready !== 0 || level !== LW'(DEP)) begin
            errors++;
            $display("FAIL full_state: got ready=%0b level=%0d, required 0 %0d", up_if.ready, level, DEP);
        end
        up_if.valid = 1; up_if.data = 8'(DEP);
        idle(1);
        down_if.ready = 1;
        @(negedge clk);
        checks++;
        if (up_if.ready !== 0 || level !== LW'(DEP)) begin
            errors++;
            $display("FAIL full_pop_cycle: got ready=%0b level=%0d, required 0 %0d", up_if.ready, level, DEP);
        end
        @(posedge clk); #1;
        checks++;
        if (up_if.ready !== 1 || level !== LW'(DEP - 1)) begin
            errors++;
            $display("FAIL ready_return: got ready=%0b level=%0d, required 1 %0d", up_if.ready, level, DEP - 1);
        end
        for (int i = DEP; i < OW * OH; i++) send(0, 8'(i));
        idle(DEP + 2);
        checks++;
        if (exp_q.size() != 0 || level !== 0) begin
            errors++;
            $display("FAIL drain: got pending=%0d level=%0d, required 0 0", exp_q.size(), level);
        end
    endtask

    task automatic test_sof_early();
        logic [DW-1:0] d;
        do_reset();
        down_if.ready = 1;
        send(1, 8'h20); send(0, 8'h21); send(1, 8'h22);
        checks++;
        if (down_if.tuser !== 1 || err_early !== 1 || err_missing !== 0) begin
            errors++;
            $display("FAIL sof_early_flag: got tuser=%0b early=%0b missing=%0b, required 1 1 0", down_if.tuser, err_early, err_missing);
        end
        for (int i = 1; i < 2 * OW; i++) begin
            d = 8'(8'h22 + i);
            send(0, d);
            checks++;
            if (down_if.data !== d || down_if.tlast !== (i % OW == OW - 1)) begin
                errors++;
                $display("FAIL sof_early_tlast%0d: got d=%0h last=%0b, required d=%0h last=%0b", i, down_if.data, down_if.tlast, d, (i % OW == OW - 1));
            end
        end
        idle(2);
    endtask

    task automatic test_sof_missing();
        do_reset();
        down_if.ready = 1;
        for (int i = 0; i < OW * OH; i++) send(i == 0, 8'(8'h40 + i));
        checks++;
        if (err_missing !== 0) begin
            errors++;
            $display("FAIL missing_premature: got %0b, required 0", err_missing);
        end
        for (int i = 0; i < OW * OH; i++) begin
            send(0, 8'(8'h50 + i));
            checks++;
            if (down_if.tlast !== (i % OW == OW - 1) || err_missing !== 1 || err_early !== 0) begin
                errors++;
                $display("FAIL missing_beat%0d: got last=%0b missing=%0b early=%0b, required %0b 1 0", i,
                         down_if.tlast, err_missing, err_early, (i % OW == OW - 1));
            end
        end
        idle(2);
    endtask

    task automatic test_random();
        bit prod_done = 0;
        bit tu;
        int n = 0;
        do_reset();
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        up_if.valid = 0;
                        idle(1);
                    end
                    tu = (i % (OW * OH) == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 49) == 0);
                    send(tu, 8'($urandom));
                end
                prod_done = 1;
            end
            begin
                while (!prod_done) begin
                    down_if.ready = 1'($urandom_range(0, 1));
                    idle(1);
                end
            end
        join
        down_if.ready = 1;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d pending, required 0", exp_q.size());
        end
        checks++;
        if (err_early !== m_early || err_missing !== m_missing) begin
            errors++;
            $display("FAIL random_flags: got early=%0b missing=%0b, required %0b %0b", err_early, err_missing, m_early, m_missing);
        end
    endtask

    task automatic test_reset_mid();
        down_if.ready = 0;
        send(0, 8'h71); send(1, 8'h72); send(1, 8'h73);
        checks++;
        if (level !== 3 || err_early !== 1) begin
            errors++;
            $display("FAIL pre_reset: got level=%0d early=%0b, required 3 1", level, err_early);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (down_if.valid !== 0 || level !== 0 || err_early !== 0 || err_missing !== 0 || up_if.ready !== 1) begin
            errors++;
            $display("FAIL mid_reset: got valid=%0b level=%0d early=%0b missing=%0b ready=%0b, required 0 0 0 0 1",
                     down_if.valid, level, err_early, err_missing, up_if.ready);
        end
        model_clear();
        @(posedge clk); #1;
        rst = 0;
        down_if.ready = 1;
        for (int i = 0; i < OW * OH; i++) begin
            send(i == 0, 8'(8'h80 + i));
            checks++;
            if (down_if.tlast !== (i % OW == OW - 1) || down_if.tuser !== (i == 0)) begin
                errors++;
                $display("FAIL post_reset_beat%0d: got last=%0b user=%0b, required %0b %0b", i, down_if.tlast, down_if.tuser,
                         (i % OW == OW - 1), (i == 0));
            end
        end
        idle(3);
        checks++;
        if (exp_q.size() != 0 || err_early !== 0 || err_missing !== 0) begin
            errors++;
            $display("FAIL post_reset_end: got pending=%0d early=%0b missing=%0b, required 0 0 0", exp_q.size(), err_early, err_missing);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_sof_early();
        test_sof_missing();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gl4_reframe.md
# gl4_reframe

Output framing stage placed directly downstream of the 2x2 pixel/line decimator. The decimator forwards only every second pixel of every second line, so its end-of-line marker, which rides on a dropped odd pixel, never reaches the output with valid set. This block buffers the decimated stream in a small FIFO, regenerates `tlast` from a column counter at the output line width, and realigns on start-of-frame (`tuser`). It also reports framing errors through sticky flags.

## Interface
Parameters:
- `D_WIDTH`, default 8: pixel data width.
- `OUT_W`, default 960: output pixels per line. Must be ≥ 2.
- `OUT_H`, default 540: output lines per frame. Must be ≥ 2.
- `DEPTH`, default 16: FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `up_data`  in  D_WIDTH: pixel from the decimator.
- `up_valid`  in  1: beat valid.
- `up_tlast`  in  1: ignored; the block regenerates `tlast`.
- `up_tuser`  in  1: start of frame, valid on the first pixel of a frame.
- `up_ready`  out  1: `!full`.
- `down_data`  out  D_WIDTH: buffered pixel.
- `down_valid`  out  1: `!empty`.
- `down_tlast`  out  1: regenerated end of line.
- `down_tuser`  out  1: start of frame, forwarded.
- `down_ready`  in  1: consumer accept.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `err_sof_early`  out  1: sticky; `tuser` arrived while `col != 0` or `row != 0`.
- `err_sof_missing`  out  1: sticky; frame position (0,0) accepted without `tuser`.

## Operation
- A push happens when `up_valid & up_ready`. A pop happens when `down_valid & down_ready`.
- Write-side position tracker, updated on each push:
  - `col` is $clog2(OUT_W) bits wide; `row` is $clog2(OUT_H) bits wide.
  - Effective column: `ec = up_tuser ? 0 : col`. Effective row: `er = up_tuser ? 0 : row`.
  - Stored `tlast` = `(ec == OUT_W-1)`. Stored `tuser` = `up_tuser`.
  - If `ec == OUT_W-1`: `col` becomes 0, and `row` becomes `(er == OUT_H-1) ? 0 : er+1`.
  - Otherwise: `col` becomes `ec+1` and `row` becomes `er`.
- Error flags:
  - `err_sof_early` is set when a push has `up_tuser=1` and (`col != 0` or `row != 0`).
  - `err_sof_missing` is set when a push has `up_tuser=0` with `col == 0` and `row == 0` and `seen_sof == 1`.
  - `seen_sof` is set by the first pushed `tuser` after reset. Before the first `tuser`, missing-SOF is not flagged.
  - Both error flags clear only on reset.
- An early `tuser` realigns the counters to (0,0) and the beat is still stored. The truncated previous line gets no `tlast`; this is intended.
- FIFO contents: entries hold `{tuser, tlast, data}`. Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
- The `down_*` outputs are driven from the entry at the read pointer (first-word fall-through).

## Timing
- Reset, asynchronous: pointers, `col`, `row`, `seen_sof` and both error flags go to 0. After reset: `down_valid=0`, `up_ready=1`, `level=0`, `down_tlast=0`, `down_tuser=0`, `down_data=0`.
- Latency: a beat pushed in cycle N is presented on `down_*` in cycle N+1. There is no combinational bypass from empty.
- Full: `up_ready=0`. A push is refused even when a pop occurs in the same cycle; `up_ready` rises in the cycle after the pop.
- Empty: `down_valid=0`, and `down_*` must not change spuriously.
- Simultaneous push and pop when neither full nor empty: `level` is unchanged.
- Pointer wrap: both pointers wrap modulo 2·DEPTH with no bubble.
- `down_*` must be held stable while `down_valid & !down_ready`.
- Reset mid-stream: FIFO contents are discarded and framing restarts, expecting `tuser`.

## Structure
- Shared package `gl_video_pkg`:
  - `typedef struct packed {logic tuser; logic tlast; logic [D_WIDTH-1:0] data;} beat_t`, parameterised by a package localparam or redeclared locally.
  - Counter width helper via `$clog2`.
- Sub-module `gl4_fifo`: generic synchronous first-word-fall-through FIFO, parameterised on width and depth, with a `level` output.
- `gl4_reframe` holds the position tracker, the error logic and the FIFO instance.

## Test plan
- OUT_W=4, OUT_H=2, DEPTH=4. Push one frame of 8 beats, `tuser` on beat 0, `down_ready=1` -> `down_tlast` on beats 3 and 7, `down_tuser` only on beat 0, no errors, each beat out one cycle after it goes in.
- Same frame with `down_ready=0` -> `up_ready` drops after 4 pushes and `level=4`. Raise `down_ready` -> `up_ready` returns the next cycle; data order is 0..7 with no loss or duplication.
- `tuser` injected at col=2 of line 0 -> `err_sof_early=1`; that beat is output with `tuser=1`, and the next `tlast` comes 3 beats later (col 3).
- Two frames where the second frame lacks `tuser` on its first beat -> `err_sof_missing=1`; `tlast` cadence unchanged.
- Random `up_valid`/`down_ready` at 50% for 1000 beats -> scoreboard match, and `down_*` held stable while stalled.
- Assert `rst` with `level=3` -> immediately `down_valid=0`, `level=0`, flags cleared; the next frame frames correctly.
